mem_access_unit: RTL

Memory-access control for the MEM stage. Takes the EX/MEM pipeline register's memory request and drives the byte-addressed data memory (9-bit address, big-endian, combinational read, synchronous write). It sign- or zero-extends load data, sequences SPARC doubleword LDD/STD as two word accesses, and detects misaligned accesses. Its output is the MEM/WB pipeline register feeding writeback.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_access_unit_load_formatter.sv | 16 +
 rtl/mem_access_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: access-type and size encodings, FSM states and width defaults for the MEM stage
package mem_pkg;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
    localparam logic [2:0] OP_UB = 3'b000;
    localparam logic [2:0] OP_SB = 3'b001;
    localparam logic [2:0] OP_UH = 3'b010;
    localparam logic [2:0] OP_SH = 3'b011;
    localparam logic [2:0] OP_W  = 3'b100;
    localparam logic [2:0] OP_D  = 3'b101;
    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] SZ_W  = 2'b10;
    typedef enum logic {IDLE, DBL2} st_e;
endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: zero/sign extension of sub-word load data by access type
module load_formatter
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    always_comb
        dout = op == OP_UB ? DATA_W'(din[7:0]) :
               op == OP_SB ? {{(DATA_W-8){din[7]}}, din[7:0]} :
               op == OP_UH ? DATA_W'(din[15:0]) :
               op == OP_SH ? {{(DATA_W-16){din[15]}}, din[15:0]} : din;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory control with load extension, LDD/STD sequencing
// and misalignment traps, registering the MEM/WB stage.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_sdata,
    input  logic [DATA_W-1:0] ex_sdata2,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic [4:0]        ex_rd,
    input  logic              ex_rf_le,
    input  logic              flush,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_di,
    output logic [1:0]        dm_size,
    output logic              dm_rw,
    output logic              dm_e,
    input  logic [DATA_W-1:0] dm_do,
    output logic              stall_req,
    output logic              wb_valid,
    output logic              wb_rf_le,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              trap_misalign
);
    st_e state;
    logic [DATA_W-1:0] ld_data;
    logic legal, mem_op, dbl, aligned, active, in_dbl2, misalign, wr;

    load_formatter #(.DATA_W(DATA_W)) u_fmt (.op(ex_op), .din(dm_do), .dout(ld_data));

    // rst_n gates active so write enable and stall drop the moment reset asserts
    always_comb begin
        legal = ex_op <= OP_D;
        mem_op = (ex_load || ex_store) && legal;
        dbl = ex_op == OP_D;
        aligned = ex_op[2] ? (dbl ? ex_addr[2:0] == 3'd0 : ex_addr[1:0] == 2'd0) :
                  (ex_op[1] ? !ex_addr[0] : 1'b1);
        active = rst_n && ex_valid && !flush;
        in_dbl2 = state == DBL2;
        misalign = active && mem_op && !aligned && !in_dbl2;
        wr = active && ex_store && legal && (in_dbl2 || aligned);
        stall_req = active && !in_dbl2 && mem_op && dbl && aligned;
        dm_addr = in_dbl2 ? ex_addr + ADDR_W'(4) : ex_addr;
        dm_size = in_dbl2 ? SZ_W : (ex_op[2] ? SZ_W : (ex_op[1] ? SZ_H : SZ_B));
        dm_di = in_dbl2 ? ex_sdata2 : ex_sdata;
        dm_e = wr;
        dm_rw = wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wb_valid <= 1'b0;
            wb_rf_le <= 1'b0;
            wb_rd <= 5'd0;
            wb_data <= '0;
            trap_misalign <= 1'b0;
        end else begin
            state <= stall_req ? DBL2 : IDLE;
            wb_valid <= active;
            trap_misalign <= misalign;
            if (!active || misalign) begin
                wb_rf_le <= 1'b0;
            end else if (in_dbl2) begin
                wb_rf_le <= ex_load && ex_rf_le;
                if (ex_load) begin
                    wb_rd <= ex_rd | 5'b00001;
                    wb_data <= ld_data;
                end
            end else if (mem_op && ex_load) begin
                wb_rf_le <= ex_rf_le;
                wb_rd <= dbl ? ex_rd & 5'b11110 : ex_rd;
                wb_data <= ld_data;
            end else if (mem_op) begin
                wb_rf_le <= 1'b0;
            end else begin
                wb_rf_le <= ex_rf_le;
                wb_rd <= ex_rd;
                wb_data <= ex_alu;
            end
        end
    end
endmodule
